// File: rtl/sha_req_arbiter.sv
// Round-robin front end for a single shared SHA-256 engine.
// One single-block message is in flight at a time: a requester is granted,
// its message is issued to the engine, and the digest (or an error for an
// oversized request or a hung engine) is returned tagged with the requester id.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no transaction; grant the next requester round-robin
// ISSUE  | one-cycle strobe of the latched message into the engine
// WAIT   | engine busy; watchdog timer running
// RESP   | response held on rsp_* until the consumer takes it
module sha_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 256,
  parameter int MAX_BYTES   = 55
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*6-1:0]       req_byte_valid,
  input  logic [NUM_REQ*440-1:0]     req_msg,
  output logic                       eng_msg_valid,
  output logic [5:0]                 eng_byte_valid,
  output logic [439:0]               eng_msg_word,
  input  logic                       eng_hash_done,
  input  logic [255:0]               eng_fin_hash,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [255:0]               rsp_hash,
  output logic                       rsp_err,
  output logic                       busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   grant_id;
  logic              any_req;
  logic [5:0]        sel_bytes;
  logic [439:0]      sel_msg;
  logic              bytes_bad;
  logic              accept;
  logic              timeout;
  logic [TMR_W-1:0]  timer_q;

  // Position of requester (base + off) on the ring, wrapping at NUM_REQ.
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_W'(sum);
  endfunction

  // Round-robin search starting just after the last requester served.
  always_comb begin
    grant_id = '0;
    any_req  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!any_req && req_valid[rr_index(rr_ptr_q, k)]) begin
        any_req  = 1'b1;
        grant_id = rr_index(rr_ptr_q, k);
      end
    end
  end

  // Select the granted requester's payload and screen its byte count.
  always_comb begin
    sel_bytes = req_byte_valid[6*grant_id +: 6];
    sel_msg   = req_msg[440*grant_id +: 440];
    bytes_bad = sel_bytes > 6'(MAX_BYTES);
    accept    = (state_q == S_IDLE) && any_req;
    timeout   = timer_q == TMR_W'(TIMEOUT_CYC - 1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a finished engine beats the watchdog in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) state_d = bytes_bad ? S_RESP : S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (eng_hash_done || timeout) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore-style handshake outputs plus the one-hot accept pulse.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
    eng_msg_valid = (state_q == S_ISSUE);
    rsp_valid     = (state_q == S_RESP);
    busy          = (state_q != S_IDLE);
  end

  // Watchdog: cleared on issue, counts every WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst)                    timer_q <= '0;
    else if (state_q == S_ISSUE) timer_q <= '0;
    else if (state_q == S_WAIT)  timer_q <= timer_q + 1'b1;
  end

  // Engine-side payload; loaded only for legal requests so it holds between issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      eng_byte_valid <= '0;
      eng_msg_word   <= '0;
    end else if (accept && !bytes_bad) begin
      eng_byte_valid <= sel_bytes;
      eng_msg_word   <= sel_msg;
    end
  end

  // Response payload: id at grant, digest or error when the transaction resolves.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_id   <= '0;
      rsp_hash <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (accept) begin
        rsp_id <= grant_id;
        if (bytes_bad) begin
          rsp_err  <= 1'b1;
          rsp_hash <= '0;
        end
      end
      if (state_q == S_WAIT) begin
        if (eng_hash_done) begin
          rsp_hash <= eng_fin_hash;
          rsp_err  <= 1'b0;
        end else if (timeout) begin
          rsp_hash <= '0;
          rsp_err  <= 1'b1;
        end
      end
    end
  end

  // Fairness pointer advances only once the response has been taken.
  always_ff @(posedge clk) begin
    if (rst)                                rr_ptr_q <= ID_W'(NUM_REQ - 1);
    else if (state_q == S_RESP && rsp_ready) rr_ptr_q <= rsp_id;
  end

endmodule
